// File: rtl/mux_arb_8_if.sv
// Handshake/bus bundle for mux_arb_8: four source byte lanes in, one merged byte out.
// slave = arbiter side, master = producers/consumer side.
interface mux_arb_8_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in3;
    logic [DATA_W-1:0] in4;
    logic [3:0]        in_vld;
    logic [3:0]        in_rdy;
    logic [DATA_W-1:0] Y;
    logic [1:0]        Sel;
    logic              Y_vld;
    logic              Y_rdy;

    modport slave (
        input  in1, in2, in3, in4, in_vld, Y_rdy,
        output in_rdy, Y, Sel, Y_vld
    );

    modport master (
        output in1, in2, in3, in4, in_vld, Y_rdy,
        input  in_rdy, Y, Sel, Y_vld
    );
endinterface

// File: rtl/mux_arb_8.sv
// Four-channel round-robin byte merger with one-entry holding registers per channel.
// Optional sticky per-channel overflow flags when MUX_ARB_8_OVERFLOW_EN is defined.
module mux_arb_8 #(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    mux_arb_8_if.slave     bus
`ifdef MUX_ARB_8_OVERFLOW_EN
    ,
    output logic [3:0]     ovf
`endif
);

    logic [1:0]        rst_sync;
    logic              rst_int_n;

    logic [DATA_W-1:0] in_byte [4];
    logic [DATA_W-1:0] hold    [4];
    logic [3:0]        full;
    logic [1:0]        last_grant;

    logic [DATA_W-1:0] y_q;
    logic [1:0]        sel_q;
    logic              y_vld_q;

    logic              load;
    logic              gnt_found;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [3:0]        gnt_onehot;
    logic [3:0]        capture;
    logic [3:0]        drop;

    // Assertion is immediate; release reaches the datapath only after two clk edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    assign in_byte[0] = bus.in1;
    assign in_byte[1] = bus.in2;
    assign in_byte[2] = bus.in3;
    assign in_byte[3] = bus.in4;

    assign load    = ~y_vld_q | bus.Y_rdy;
    assign capture = bus.in_vld & ~full;
    assign drop    = bus.in_vld & full;

    // Search starts one past the last winner; k=4 wraps back onto last_grant itself.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!gnt_found && full[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_onehot = 4'b0000;
        if (load && gnt_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // A full channel never captures, so drain and capture of one channel cannot collide.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            full <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= '0;
            end
        end else begin
            full <= (full & ~gnt_onehot) | capture;
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    hold[i] <= in_byte[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            y_q        <= '0;
            sel_q      <= 2'd0;
            y_vld_q    <= 1'b0;
            last_grant <= 2'd3;
        end else if (load) begin
            if (gnt_found) begin
                y_q        <= hold[gnt_idx];
                sel_q      <= gnt_idx;
                y_vld_q    <= 1'b1;
                last_grant <= gnt_idx;
            end else begin
                y_vld_q    <= 1'b0;
            end
        end
    end

    assign bus.in_rdy = ~full;
    assign bus.Y      = y_q;
    assign bus.Sel    = sel_q;
    assign bus.Y_vld  = y_vld_q;

`ifdef MUX_ARB_8_OVERFLOW_EN
    logic [3:0] ovf_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ovf_q <= 4'b0000;
        end else begin
            ovf_q <= ovf_q | drop;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_mux_arb_8.sv
// Self-checking bench for mux_arb_8: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of channels and output slot.
module tb_mux_arb_8;

    logic clk;
    logic reset_n;

    mux_arb_8_if #(.DATA_W(8)) bus ();

`ifdef MUX_ARB_8_OVERFLOW_EN
    logic [3:0] ovf;
    mux_arb_8 #(.DATA_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus), .ovf(ovf));
`else
    mux_arb_8 #(.DATA_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: each channel is a slot that is empty or holds one byte;
    // the output is a slot refilled from the next occupied channel after the last winner.
    bit         m_full [4];
    logic [7:0] m_hold [4];
    int         m_last;
    bit         m_yv;
    logic [7:0] m_y;
    int         m_sel;
    logic [3:0] m_ovf;
    int         m_skip;

    always @(posedge clk or negedge reset_n) begin
        bit         pf [4];
        logic [7:0] b  [4];
        int         g;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 0;
                m_hold[i] = 8'h00;
            end
            m_last = 3;
            m_yv   = 0;
            m_y    = 8'h00;
            m_sel  = 0;
            m_ovf  = 4'h0;
            m_skip = 2;
        end else if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else begin
            b[0] = bus.in1; b[1] = bus.in2; b[2] = bus.in3; b[3] = bus.in4;
            for (int i = 0; i < 4; i++) pf[i] = m_full[i];
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && pf[(m_last + k) % 4]) g = (m_last + k) % 4;
            end
            if (!m_yv || bus.Y_rdy) begin
                if (g >= 0) begin
                    m_y    = m_hold[g];
                    m_sel  = g;
                    m_yv   = 1;
                    m_last = g;
                end else begin
                    m_yv = 0;
                end
            end else begin
                g = -1;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.in_vld[i]) begin
                    if (pf[i]) m_ovf[i] = 1'b1;
                    else begin
                        m_full[i] = 1;
                        m_hold[i] = b[i];
                    end
                end
            end
            if (g >= 0) m_full[g] = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_rdy();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ~m_full[i];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("y_vld", {31'd0, bus.Y_vld}, {31'd0, m_yv});
        chk("y", {24'd0, bus.Y}, {24'd0, m_y});
        chk("sel", {30'd0, bus.Sel}, m_sel);
        chk("in_rdy", {28'd0, bus.in_rdy}, {28'd0, m_rdy()});
`ifdef MUX_ARB_8_OVERFLOW_EN
        chk("ovf", {28'd0, ovf}, {28'd0, m_ovf});
`endif
    endtask

    task automatic lit(input string name, input logic vld, input logic [7:0] y, input logic [1:0] sel);
        chk({name, "_vld"}, {31'd0, bus.Y_vld}, {31'd0, vld});
        chk({name, "_model_vld"}, {31'd0, m_yv}, {31'd0, vld});
        if (vld) begin
            chk({name, "_y"}, {24'd0, bus.Y}, {24'd0, y});
            chk({name, "_model_y"}, {24'd0, m_y}, {24'd0, y});
            chk({name, "_sel"}, {30'd0, bus.Sel}, {30'd0, sel});
            chk({name, "_model_sel"}, m_sel, {30'd0, sel});
        end
    endtask

    task automatic idle_inputs();
        bus.in_vld = 4'h0;
        bus.in1 = 8'h00; bus.in2 = 8'h00; bus.in3 = 8'h00; bus.in4 = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_y_vld", {31'd0, bus.Y_vld}, 32'd0);
        chk("rst_in_rdy", {28'd0, bus.in_rdy}, 32'hF);
        chk("rst_y", {24'd0, bus.Y}, 32'h00);
        chk("rst_sel", {30'd0, bus.Sel}, 32'd0);
        idle_inputs();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.Y_rdy = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte on channel 2
        do_reset();
        bus.Y_rdy = 1'b1;
        bus.in_vld = 4'b0100; bus.in3 = 8'hA5;
        tick();
        chk("single_in_rdy", {28'd0, bus.in_rdy}, 32'hB);
        idle_inputs();
        tick();
        lit("single", 1'b1, 8'hA5, 2'd2);
        tick();
        lit("single_after", 1'b0, 8'h00, 2'd0);

        // Round-robin over four full channels
        do_reset();
        bus.Y_rdy = 1'b1;
        bus.in_vld = 4'hF;
        bus.in1 = 8'h10; bus.in2 = 8'h20; bus.in3 = 8'h30; bus.in4 = 8'h40;
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] e;
            e = 8'h10 * 8'(k + 1);
            tick();
            lit("rr", 1'b1, e, 2'(k));
        end
        tick();
        lit("rr_end", 1'b0, 8'h00, 2'd0);

        // Backpressure then drain
        do_reset();
        bus.Y_rdy = 1'b0;
        bus.in_vld = 4'hF;
        bus.in1 = 8'h51; bus.in2 = 8'h52; bus.in3 = 8'h53; bus.in4 = 8'h54;
        tick();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            tick();
            lit("bp_hold", 1'b1, 8'h51, 2'd0);
        end
        bus.Y_rdy = 1'b1;
        tick(); lit("bp_drain1", 1'b1, 8'h52, 2'd1);
        tick(); lit("bp_drain2", 1'b1, 8'h53, 2'd2);
        tick(); lit("bp_drain3", 1'b1, 8'h54, 2'd3);
        tick(); lit("bp_empty", 1'b0, 8'h00, 2'd0);

        // Drop on a full channel
        do_reset();
        bus.Y_rdy = 1'b0;
        bus.in_vld = 4'b0010; bus.in2 = 8'h22;
        tick();
        idle_inputs();
        tick();
        lit("drop_first", 1'b1, 8'h22, 2'd1);
        bus.in_vld = 4'b0010; bus.in2 = 8'h33;
        tick();
        chk("drop_in_rdy", {28'd0, bus.in_rdy}, 32'hD);
        bus.in_vld = 4'b0010; bus.in2 = 8'hEE;
        tick();
        idle_inputs();
`ifdef MUX_ARB_8_OVERFLOW_EN
        chk("drop_ovf", {28'd0, ovf}, 32'h2);
`endif
        bus.Y_rdy = 1'b1;
        tick(); lit("drop_second", 1'b1, 8'h33, 2'd1);
        tick(); lit("drop_after", 1'b0, 8'h00, 2'd0);
        chk("drop_y_not_ee", {24'd0, bus.Y}, 32'h33);

        // Wrap: last grant 3, channels 0 and 3 full
        do_reset();
        bus.Y_rdy = 1'b1;
        bus.in_vld = 4'b1001; bus.in1 = 8'hA0; bus.in4 = 8'hD3;
        tick();
        idle_inputs();
        tick(); lit("wrap0", 1'b1, 8'hA0, 2'd0);
        tick(); lit("wrap3", 1'b1, 8'hD3, 2'd3);
        tick(); lit("wrap_end", 1'b0, 8'h00, 2'd0);

        // Randomized traffic with occasional mid-run reset
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            bus.in_vld = 4'($urandom);
            bus.in1 = 8'($urandom); bus.in2 = 8'($urandom);
            bus.in3 = 8'($urandom); bus.in4 = 8'($urandom);
            bus.Y_rdy = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arb_8.md
MUX_ARB_8 -- requirements
Module: mux_arb_8

Interface
REQ-001 Parameter: DATA_W, default 8, width of every data byte path.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in1, in2, in3, in4  input  DATA_W each  source bytes for channels 0..3.
REQ-005 Port: in_vld  input  4  bit i = channel i presents a byte this cycle.
REQ-006 Port: in_rdy  output  4  bit i = channel i holding register empty; registered, no combinational path from any input.
REQ-007 Port: Y  output  DATA_W  merged output byte.
REQ-008 Port: Sel  output  2  channel index that produced Y.
REQ-009 Port: Y_vld  output  1  Y/Sel valid.
REQ-010 Port: Y_rdy  input  1  downstream accepts Y when Y_vld & Y_rdy at a rising edge.

Function
REQ-011 Each channel SHALL have a one-entry holding register plus full flag; in_rdy[i] = ~full[i].
REQ-012 Capture: in_vld[i] & ~full[i] at an edge SHALL load the byte and set full[i].
REQ-013 in_vld[i] & full[i] SHALL drop the byte and leave the holding register unchanged, even if that register drains in the same cycle.
REQ-014 Output stage SHALL be a single register (Y, Sel, Y_vld); it loads when ~Y_vld or (Y_vld & Y_rdy).
REQ-015 On load, a round-robin arbiter SHALL grant the first full channel searching ascending from (last_grant+1) mod 4, wrapping 3->0.
REQ-016 Grant SHALL copy that channel's byte to Y, its index to Sel, set Y_vld, clear full[grant], and update last_grant.
REQ-017 If no channel is full at a load opportunity, Y_vld SHALL go/stay 0; Y and Sel SHALL hold their previous values.
REQ-018 While Y_vld & ~Y_rdy, Y, Sel and Y_vld SHALL hold stable; holding registers continue to capture.
REQ-019 Latency: byte captured at edge N SHALL appear on Y at edge N+1 at earliest.
REQ-020 Throughput: with Y_rdy held high, one byte per cycle SHALL be sustained.
REQ-021 Ordering: bytes from the same channel SHALL leave in arrival order; no byte is duplicated.

Reset
REQ-022 reset_n low SHALL asynchronously clear full[3:0], Y_vld, Y, Sel and the overflow state, set in_rdy = 4'b1111, and set last_grant = 3 so channel 0 wins first.
REQ-023 Reset mid-operation SHALL discard all held and pending bytes; first grant after release follows REQ-022.
REQ-024 Deassertion SHALL be synchronised to clk internally (two-stage) before state leaves reset.

Configuration
REQ-025 Macro MUX_ARB_8_OVERFLOW_EN defined: add output ovf (4 bits); ovf[i] SHALL set sticky on any REQ-013 drop for channel i and clear only on reset.
REQ-026 Macro MUX_ARB_8_OVERFLOW_EN undefined: ovf port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset: reset_n=0 mid-traffic -> Y_vld=0, in_rdy=4'b1111, Y=8'h00, Sel=0 immediately, without waiting for clk.
REQ-028 Single byte: in_vld=4'b0100, in3=8'hA5 for one cycle, Y_rdy=1 -> next cycle Y=8'hA5, Sel=2, Y_vld=1 for exactly one cycle.
REQ-029 Round-robin: all four channels full (8'h10, 8'h20, 8'h30, 8'h40) after reset, Y_rdy=1 -> Y sequence 10, 20, 30, 40 with Sel 0, 1, 2, 3 on consecutive cycles.
REQ-030 Backpressure: Y_rdy=0 for 5 cycles with Y_vld=1 -> Y/Sel stable; after Y_rdy=1, output drains in arbiter order with no loss.
REQ-031 Drop: channel 1 full, in_vld[1]=1 with in2=8'hEE while Y_rdy=0 -> 8'hEE never appears on Y; ovf[1]=1 when MUX_ARB_8_OVERFLOW_EN is defined.
REQ-032 Wrap: last_grant=3, channels 0 and 3 full -> channel 0 granted first, then channel 3.
